// File: rtl/lamp_level_ctrl_pkg.sv
// Shared types and helpers for the lamp level controller: state encoding,
// datapath widths, and the sensor-to-lamp-count mapping.
package lamp_level_ctrl_pkg;

  localparam int LEVEL_W = 8;
  localparam int COUNT_W = 4;

  typedef enum logic [1:0] {
    LL_IDLE = 2'd0,
    LL_UP   = 2'd1,
    LL_DOWN = 2'd2
  } ll_state_e;

  // Absolute difference of two sensor levels, widened so it can never wrap.
  function automatic logic [LEVEL_W:0] level_diff(input logic [LEVEL_W-1:0] a,
                                                  input logic [LEVEL_W-1:0] b);
    if (a >= b) return {1'b0, a} - {1'b0, b};
    else        return {1'b0, b} - {1'b0, a};
  endfunction

  // Darker ambient light asks for more lamps: 0 (bright) .. 15 (dark).
  function automatic logic [COUNT_W-1:0] sensor_target(input logic [LEVEL_W-1:0] level);
    logic [LEVEL_W-1:0] dark;
    dark = 8'd255 - level;
    return COUNT_W'(dark >> 4);
  endfunction

endpackage

// File: rtl/lamp_level_ctrl_step_tick_gen.sv
// Ramp pacing: one-cycle tick every DIV cycles while run is high; clr restarts
// the count from zero so the next tick lands a full DIV cycles later.
module step_tick_gen #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/lamp_level_ctrl.sv
// Ambient-light to lamp-count controller with sample hysteresis and a
// one-lamp-per-step ramp. Optional manual override: LAMP_MANUAL_OVERRIDE_EN.
module lamp_level_ctrl
  import lamp_level_ctrl_pkg::*;
#(
  parameter int STEP_DIV = 1000,
  parameter int HYST     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sensor_valid,
  input  logic [LEVEL_W-1:0] sensor_level,
  input  logic               enable,
  output logic [COUNT_W-1:0] active_lights,
  output logic               ramping
`ifdef LAMP_MANUAL_OVERRIDE_EN
  ,
  input  logic               manual_valid,
  input  logic [COUNT_W-1:0] manual_count,
  input  logic               manual_clear
`endif
);

  logic [LEVEL_W-1:0] level_reg;
  logic [COUNT_W-1:0] target;
  ll_state_e          state, state_next;
  logic               tick, tick_clr, step_up, step_dn;

  // Reset value 8'hFF reads as "fully bright", so the lamps start off.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_reg <= 8'hFF;
    end else if (sensor_valid && (level_diff(sensor_level, level_reg) >= (LEVEL_W+1)'(HYST))) begin
      level_reg <= sensor_level;
    end
  end

`ifdef LAMP_MANUAL_OVERRIDE_EN
  logic               override;
  logic [COUNT_W-1:0] man_reg;

  // A new manual request wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      override <= 1'b0;
      man_reg  <= '0;
    end else if (manual_valid) begin
      override <= 1'b1;
      man_reg  <= manual_count;
    end else if (manual_clear) begin
      override <= 1'b0;
    end
  end

  assign target = override ? man_reg : (enable ? sensor_target(level_reg) : '0);
`else
  assign target = enable ? sensor_target(level_reg) : '0;
`endif

  step_tick_gen #(
    .DIV (STEP_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .run  (state != LL_IDLE),
    .tick (tick)
  );

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    tick_clr   = 1'b0;
    step_up    = 1'b0;
    step_dn    = 1'b0;
    unique case (state)
      LL_IDLE: begin
        if (target > active_lights) begin
          state_next = LL_UP;
          tick_clr   = 1'b1;
        end else if (target < active_lights) begin
          state_next = LL_DOWN;
          tick_clr   = 1'b1;
        end
      end
      LL_UP: begin
        if (target < active_lights) begin
          state_next = LL_DOWN;
          tick_clr   = 1'b1;
        end else if (target == active_lights) begin
          state_next = LL_IDLE;
        end else if (tick) begin
          step_up = 1'b1;
          if (active_lights + COUNT_W'(1) == target) state_next = LL_IDLE;
        end
      end
      LL_DOWN: begin
        if (target > active_lights) begin
          state_next = LL_UP;
          tick_clr   = 1'b1;
        end else if (target == active_lights) begin
          state_next = LL_IDLE;
        end else if (tick) begin
          step_dn = 1'b1;
          if (active_lights - COUNT_W'(1) == target) state_next = LL_IDLE;
        end
      end
      default: state_next = LL_IDLE;
    endcase
  end

  // Steps only fire while strictly short of target, so the count cannot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= LL_IDLE;
      active_lights <= '0;
      ramping       <= 1'b0;
    end else begin
      state   <= state_next;
      ramping <= (state_next != LL_IDLE);
      if (step_up)      active_lights <= active_lights + COUNT_W'(1);
      else if (step_dn) active_lights <= active_lights - COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_lamp_level_ctrl.sv
// Self-checking bench for lamp_level_ctrl: directed vector table, hand-written
// ramp corner sequences, and randomized traffic against an integer model.
module tb_lamp_level_ctrl;

  localparam int STEP_DIV = 4;
  localparam int HYST     = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       sensor_valid;
  logic [7:0] sensor_level;
  logic       enable;
  logic [3:0] active_lights;
  logic       ramping;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  lamp_level_ctrl #(
    .STEP_DIV (STEP_DIV),
    .HYST     (HYST)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sensor_valid  (sensor_valid),
    .sensor_level  (sensor_level),
    .enable        (enable),
    .active_lights (active_lights),
    .ramping       (ramping)
`ifdef LAMP_MANUAL_OVERRIDE_EN
    ,
    .manual_valid  (1'b0),
    .manual_count  (4'd0),
    .manual_clear  (1'b0)
`endif
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: lamp count chases the target one step per STEP_DIV
  // cycles, counted from the start of a ramp or the last reversal.
  int m_level  = 255;
  int m_active = 0;
  int m_dir    = 0;
  int m_age    = 0;
  bit model_on = 1'b0;

  always @(posedge clk) begin : model
    int tgt, want, d;
    tgt  = enable ? (255 - m_level) / 16 : 0;
    want = (tgt > m_active) ? 1 : (tgt < m_active) ? -1 : 0;
    if (rst) begin
      m_level = 255; m_active = 0; m_dir = 0; m_age = 0;
    end else begin
      if (m_dir == 0) begin
        if (want != 0) begin m_dir = want; m_age = 0; end
      end else if (want == 0) begin
        m_dir = 0;
      end else if (want != m_dir) begin
        m_dir = want; m_age = 0;
      end else if (m_age == STEP_DIV - 1) begin
        m_active += m_dir;
        m_age = 0;
        if (m_active == tgt) m_dir = 0;
      end else begin
        m_age++;
      end
      d = int'(sensor_level) - m_level;
      if (d < 0) d = -d;
      if (sensor_valid && d >= HYST) m_level = int'(sensor_level);
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("model_active", active_lights, m_active);
      check("model_ramping", ramping, m_dir != 0);
    end
  end

  task automatic strobe(input logic [7:0] lvl);
    sensor_valid = 1'b1;
    sensor_level = lvl;
    @(negedge clk);
    sensor_valid = 1'b0;
  endtask

  task automatic wait_active(input logic [3:0] v, input int max_cyc, input string nm);
    int n = 0;
    while (active_lights !== v && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(nm, active_lights, v);
  endtask

  typedef struct {
    logic       valid;
    logic [7:0] level;
    logic       en;
    int         wait_cyc;
    logic [3:0] exp_active;
    logic       exp_ramp;
    string      name;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b1, 8'h00, 1'b1, 64, 4'd15, 1'b0, "ramp_up_to_15"};
    vecs[1] = '{1'b1, 8'h40, 1'b1, 20, 4'd11, 1'b0, "level_40_down_11"};
    vecs[2] = '{1'b1, 8'h45, 1'b1,  8, 4'd11, 1'b0, "hyst_45_dropped"};
    vecs[3] = '{1'b1, 8'h48, 1'b1,  8, 4'd11, 1'b0, "hyst_48_same_target"};
    vecs[4] = '{1'b1, 8'h80, 1'b1, 20, 4'd7,  1'b0, "ramp_down_to_7"};
    vecs[5] = '{1'b1, 8'hFF, 1'b1, 40, 4'd0,  1'b0, "ramp_down_to_0"};

    rst = 1'b1; sensor_valid = 1'b0; sensor_level = 8'h00; enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_on = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_active", active_lights, 4'd0);
      check("idle_ramping", ramping, 1'b0);
    end

    foreach (vecs[i]) begin
      enable = vecs[i].en;
      sensor_valid = vecs[i].valid;
      sensor_level = vecs[i].level;
      @(negedge clk);
      sensor_valid = 1'b0;
      repeat (vecs[i].wait_cyc) @(negedge clk);
      check({vecs[i].name, "_active"}, active_lights, vecs[i].exp_active);
      check({vecs[i].name, "_ramping"}, ramping, vecs[i].exp_ramp);
    end

    // Reversal at 5 while heading for 15: counter restarts, four-cycle wait.
    strobe(8'h00);
    wait_active(4'd5, 60, "rev_reach_5");
    strobe(8'hFF);
    check("rev_hold_a", active_lights, 4'd5);
    @(negedge clk);
    check("rev_hold_b", active_lights, 4'd5);
    check("rev_ramping", ramping, 1'b1);
    repeat (3) @(negedge clk);
    check("rev_no_early_step", active_lights, 4'd5);
    @(negedge clk);
    check("rev_first_dec", active_lights, 4'd4);
    for (int v = 3; v >= 0; v--) begin
      repeat (STEP_DIV) @(negedge clk);
      check("rev_dec", active_lights, v);
    end
    check("rev_done_ramping", ramping, 1'b0);

    // Enable drop mid-ramp: ramp down from 10, then resume toward 15.
    strobe(8'h00);
    wait_active(4'd10, 80, "en_reach_10");
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("en_no_jump", active_lights, 4'd10);
    wait_active(4'd0, 80, "en_drop_to_0");
    check("en_drop_ramping", ramping, 1'b0);
    enable = 1'b1;
    wait_active(4'd15, 100, "en_restore_15");
    check("en_restore_ramping", ramping, 1'b0);

    // Reset mid-ramp lands on 0 immediately.
    strobe(8'hFF);
    wait_active(4'd0, 100, "rst_prep_0");
    strobe(8'h00);
    wait_active(4'd7, 60, "rst_reach_7");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_active", active_lights, 4'd0);
    check("rst_ramping", ramping, 1'b0);
    repeat (10) @(negedge clk);
    check("rst_stays_active", active_lights, 4'd0);
    check("rst_stays_ramping", ramping, 1'b0);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 1500; i++) begin
      int t;
      sensor_valid = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1) == 0) begin
        sensor_level = 8'($urandom_range(0, 255));
      end else begin
        t = m_level + int'($urandom_range(0, 20)) - 10;
        if (t < 0) t = 0;
        if (t > 255) t = 255;
        sensor_level = 8'(t);
      end
      if ($urandom_range(0, 40) == 0) enable = ~enable;
      rst = ($urandom_range(0, 400) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    sensor_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/lamp_level_ctrl.md
Name: lamp_level_ctrl

Overview:
- Upstream stage of the lamp decoder. Converts an ambient-light sensor reading into a lamp count, active_lights[3:0].
- The decoder turns that count into the 16-bit lights_state one-hot/thermometer pattern.
- Adds hysteresis on sensor samples and ramps the count one lamp per step. The lamp bank never jumps abruptly.

Parameters:
- STEP_DIV, 1000: clock cycles per ramp step (>=2).
- HYST, 8: minimum absolute change in sensor_level for a new sample to be accepted.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- sensor_valid  input  1  one-cycle strobe; sensor_level is valid this cycle
- sensor_level  input  8  ambient brightness (0 = dark, 255 = bright)
- enable  input  1  house occupied; 0 forces target to 0
- active_lights  output  4  current lamp count (to decoder)
- ramping  output  1  high while active_lights != target

Behaviour:
- One clock; reset is synchronous and active-high on rst, sampled on the rising edge of clk.
- Reset values:
  - active_lights=0, ramping=0, state=IDLE.
  - level_reg=8'hFF, so the sensor-derived target is 0.
  - tick counter=0.
- Sample acceptance: on sensor_valid, if |sensor_level - level_reg| >= HYST, then level_reg <= sensor_level. Otherwise the sample is dropped.
  - Compute the difference in 9 bits; no wrap.
- Target is combinational: target = enable ? (8'd255 - level_reg) >> 4 : 4'd0. Range is 0..15.
- State machine: states are IDLE, UP and DOWN.
  - IDLE: if target > active_lights, go to UP. If target < active_lights, go to DOWN. Clear the tick counter on leaving IDLE.
  - UP: the tick counter counts 0..STEP_DIV-1. On reaching STEP_DIV-1, active_lights increments by 1 and the counter clears. When active_lights == target, go to IDLE.
  - DOWN: mirror of UP, decrementing.
  - Latency: the first step lands STEP_DIV cycles after leaving IDLE. Each later step follows STEP_DIV cycles after the previous one.
- Retarget mid-ramp:
  - If the new target is still in the same direction, continue without restarting the counter.
  - If the direction reverses, switch state in the same cycle and clear the counter.
  - If the new target equals active_lights, go to IDLE and take no step.
- Simultaneous step and target change: the step is evaluated against the target of that same cycle. active_lights never overshoots target and never leaves 0..15 (no wrap).
- enable falling mid-ramp: target becomes 0 and the block ramps down from the current value.
- ramping = (state != IDLE), registered. It is high exactly while active_lights != target. The one-cycle IDLE decision delay is allowed.
- rst mid-ramp: all registers return to reset values on the next edge. active_lights drops to 0 immediately, with no ramp.

Optional Feature:
- Macro: LAMP_MANUAL_OVERRIDE_EN.
- When the macro is defined, three extra ports are added:
  - manual_valid (input 1)
  - manual_count (input 4)
  - manual_clear (input 1)
- Override entry: manual_valid latches override=1 and man_reg<=manual_count. While override=1, target=man_reg, and enable and the sensor are ignored for targeting. level_reg still updates on accepted samples.
- Override exit: manual_clear sets override=0.
- Priority: manual_clear and manual_valid in the same cycle resolve to manual_valid.
- Reset state: override=0.
- When the macro is undefined, the ports are absent and the behaviour is exactly as above.

Decomposition:
- Shared package:
  - state encoding constants: LL_IDLE=2'd0, LL_UP=2'd1, LL_DOWN=2'd2
  - LEVEL_W=8
  - COUNT_W=4
- Sub-module step_tick_gen:
  - parameter DIV
  - inputs clk, rst, clr, run
  - output tick, a one-cycle pulse every DIV cycles while run=1; clr restarts the count.

Test Plan:
- Tests use STEP_DIV=4 and HYST=8.
- Reset then idle: after rst, active_lights=0 and ramping=0 for 20 cycles with no input.
- Ramp up: enable=1, sensor_level=0x00 strobed → target 15. active_lights goes 1,2,…,15, one step every 4 cycles. ramping drops after 15 is reached.
- Hysteresis: from level_reg=0x40, strobe 0x45 → ignored, no change. Strobe 0x48 → accepted; target goes from 11 to 11 (0xB7>>4=11), so no ramp. Strobe 0x80 → target 7, ramp down to 7.
- Reversal: mid-ramp toward 15 at active_lights=5, strobe 0xFF → target 0. State becomes DOWN the same cycle. The first decrement occurs 4 cycles later, then the count goes 4,3,2,1,0.
- enable drop: at active_lights=10, enable=0 → ramp down to 0. Re-asserting enable restores the ramp toward the sensor target.
- Reset mid-ramp: with active_lights=7 and ramping up, pulse rst for 1 cycle → next cycle active_lights=0, ramping=0, state IDLE.
